// File: rtl/sysid_pkg.sv
// Shared definitions for the sysid checker: FSM encoding, word addresses, widths.
package sysid_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WAIT_W  = 16;
  localparam int unsigned RETRY_W = 4;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CHECK,
    RETRY,
    DONE
  } state_t;

  function automatic logic is_read(state_t s);
    return (s == RD_ID) || (s == RD_TS);
  endfunction

  function automatic logic is_busy(state_t s);
    return s inside {RD_ID, RD_TS, CHECK, RETRY};
  endfunction

endpackage

// File: rtl/sysid_wait_timer.sv
// Counts consecutive stalled read cycles and flags the cycle that exhausts the budget.
module sysid_wait_timer
  import sysid_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  output logic expired_c
);

  logic [WAIT_W-1:0] count;

  // Fires on the stalled cycle that brings the count up to TIMEOUT_CYCLES.
  assign expired_c = stall && (count == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (stall && !expired_c) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Reads the sysid slave ID and timestamp words over Avalon-MM and compares them
// against the build-time expected values, with per-read timeout and retry.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'd1393886764,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              avm_address,
  output logic              avm_read,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout,
  output logic [DATA_W-1:0] captured_id,
  output logic [DATA_W-1:0] captured_ts
);

  state_t              state, state_nxt;
  logic [RETRY_W-1:0]  retry_cnt, retry_cnt_nxt;
  logic                id_ok_nxt, ts_ok_nxt, timeout_nxt;
  logic [DATA_W-1:0]   cap_id_nxt, cap_ts_nxt;
  logic                stall_c;
  logic                expired_c;

  assign stall_c = is_read(state) && avm_waitrequest;

  sysid_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (clock),
    .rst_n    (reset_n),
    .stall    (stall_c),
    .expired_c(expired_c)
  );

  // Next-state and next-value logic for every register.
  always_comb begin
    state_nxt     = state;
    retry_cnt_nxt = retry_cnt;
    id_ok_nxt     = id_ok;
    ts_ok_nxt     = ts_ok;
    timeout_nxt   = timeout;
    cap_id_nxt    = captured_id;
    cap_ts_nxt    = captured_ts;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = RD_ID;
          retry_cnt_nxt = '0;
          id_ok_nxt     = 1'b0;
          ts_ok_nxt     = 1'b0;
          timeout_nxt   = 1'b0;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          cap_id_nxt = avm_readdata;
          state_nxt  = RD_TS;
        end else if (expired_c) begin
          state_nxt = RETRY;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          cap_ts_nxt = avm_readdata;
          state_nxt  = CHECK;
        end else if (expired_c) begin
          state_nxt = RETRY;
        end
      end
      CHECK: begin
        id_ok_nxt = (captured_id == EXPECTED_ID);
        ts_ok_nxt = (captured_ts == EXPECTED_TS);
        state_nxt = DONE;
      end
      RETRY: begin
        // A retry restarts the whole sequence from the ID word.
        if (retry_cnt < RETRY_W'(MAX_RETRIES)) begin
          retry_cnt_nxt = retry_cnt + 1'b1;
          state_nxt     = RD_ID;
        end else begin
          timeout_nxt = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus strobes and status are registered from the next state so they line up with it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      retry_cnt   <= '0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      captured_id <= '0;
      captured_ts <= '0;
      avm_read    <= 1'b0;
      avm_address <= ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      retry_cnt   <= retry_cnt_nxt;
      id_ok       <= id_ok_nxt;
      ts_ok       <= ts_ok_nxt;
      timeout     <= timeout_nxt;
      captured_id <= cap_id_nxt;
      captured_ts <= cap_ts_nxt;
      avm_read    <= is_read(state_nxt);
      avm_address <= (state_nxt == RD_TS) ? ADDR_TS : ADDR_ID;
      busy        <= is_busy(state_nxt);
      done        <= (state_nxt == DONE);
    end
  end

endmodule
